// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register.
// Optional burst lock: define SHARED_REG_ARB_LOCK_EN.
module shared_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int PW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
`ifdef SHARED_REG_ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic [PW-1:0]  q_src
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  masked;
  logic [N-1:0]  pick;
  logic [N-1:0]  rr_oh;
  logic [PW-1:0] rr_idx;
  logic [N-1:0]  win_oh;
  logic [PW-1:0] win_idx;
  logic          we;
  logic          hold;

  // Rotating priority: prefer requests at or above ptr, else wrap to lowest.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (PW'(i) >= ptr);
    end
    masked = req & hi_mask;
    pick   = (|masked) ? masked : req;
    rr_oh  = pick & (~pick + 1'b1);
    rr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (rr_oh[i]) rr_idx = rr_idx | PW'(i);
    end
  end

`ifdef SHARED_REG_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        state;
  logic [PW-1:0] own;

  assign hold = (state == LOCKED) && req[own] && lock[own];

  always_comb begin
    win_oh  = rr_oh;
    win_idx = rr_idx;
    if (hold) begin
      win_oh  = '0;
      win_oh[own] = 1'b1;
      win_idx = own;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      own   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (we && lock[win_idx]) begin
            state <= LOCKED;
            own   <= win_idx;
          end
        end
        LOCKED: begin
          if (!hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign hold    = 1'b0;
  assign win_oh  = rr_oh;
  assign win_idx = rr_idx;
`endif

  assign we  = |req;
  assign gnt = rst_n ? win_oh : '0;

  // Explicit wrap so non-power-of-two N never points past N-1.
  assign ptr_nxt = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      q_src   <= '0;
      ptr     <= '0;
    end else begin
      q_valid <= we;
      if (we) begin
        q     <= data[win_idx*W +: W];
        q_src <= win_idx;
        if (!hold) ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter (N=4 main DUT, N=3 wrap DUT).
// Lock scenario runs only when SHARED_REG_ARB_LOCK_EN is defined.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  q_src;
`ifdef SHARED_REG_ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  logic [2:0]  req3;
  logic [23:0] data3;
  logic [2:0]  gnt3;
  logic [7:0]  q3;
  logic        q_valid3;
  logic [1:0]  q_src3;

  int tests;
  int fails;
  logic [9:0] sb[$];

  shared_reg_arbiter #(.N(4), .W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data(data),
`ifdef SHARED_REG_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt),
    .q(q),
    .q_valid(q_valid),
    .q_src(q_src)
  );

  shared_reg_arbiter #(.N(3), .W(8)) dut3 (
    .clk(clk),
    .rst_n(rst_n),
    .req(req3),
    .data(data3),
`ifdef SHARED_REG_ARB_LOCK_EN
    .lock(3'b000),
`endif
    .gnt(gnt3),
    .q(q3),
    .q_valid(q_valid3),
    .q_src(q_src3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every negedge out of reset, q_valid must match the
  // scoreboard occupancy and a valid write must match its entry.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("q_valid", int'(q_valid), int'(sb.size() != 0));
      if (q_valid && sb.size() != 0) begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("q", int'(q), int'(e[9:2]));
        chk("q_src", int'(q_src), int'(e[1:0]));
      end
    end
  end

  task automatic cyc(input logic [3:0] r, input logic [31:0] d,
                     input logic [3:0] eg, input string nm);
    int idx;
    req  = r;
    data = d;
    #1;
    chk(nm, int'(gnt), int'(eg));
    idx = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) idx = i;
    @(posedge clk);
    if (eg != 4'b0000) sb.push_back({d[idx*8 +: 8], 2'(idx)});
    #1;
  endtask

  logic [2:0] g3_exp [4];

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    req3  = '0;
    data3 = '0;
`ifdef SHARED_REG_ARB_LOCK_EN
    lock  = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_qv", int'(q_valid), 0);
    chk("rst_src", int'(q_src), 0);
    rst_n = 1'b1;

    // Single requester, then idle hold of A5
    cyc(4'b0100, 32'h00A5_0000, 4'b0100, "single_gnt");
    cyc(4'b0000, 32'h0, 4'b0000, "idle_gnt");
    cyc(4'b0000, 32'h0, 4'b0000, "idle_gnt");
    chk("single_hold", int'(q), 8'hA5);

    // Reset asserted mid-traffic
    cyc(4'b1111, 32'h1234_5678, 4'b1000, "pre_rst_gnt");
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_q", int'(q), 0);
    chk("mid_rst_qv", int'(q_valid), 0);
    chk("mid_rst_src", int'(q_src), 0);
    chk("mid_rst_gnt", int'(gnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b1010, 32'h4433_2211, 4'b0010, "post_rst_gnt");
    cyc(4'b1000, 32'h4433_2211, 4'b1000, "to_ptr0_gnt");

    // Fairness: all four requesting for 8 cycles
    for (int k = 0; k < 8; k++) begin
      logic [3:0] e;
      e = 4'b0001 << (k % 4);
      cyc(4'b1111, 32'h4433_2211, e, "fair_gnt");
    end

    // Idle hold of 3C, then saved pointer (3) picks requester 3 first
    cyc(4'b0100, 32'h003C_0000, 4'b0100, "w3c_gnt");
    repeat (5) cyc(4'b0000, 32'h0, 4'b0000, "idle5_gnt");
    chk("idle5_q", int'(q), 8'h3C);
    cyc(4'b1001, 32'h9900_0077, 4'b1000, "saved_ptr_gnt");
    cyc(4'b0001, 32'h0000_0055, 4'b0001, "after_idle_gnt");
    cyc(4'b0000, 32'h0, 4'b0000, "drain_gnt");

    // N=3 wrap-around: req=101 -> 0,2,0,2
    g3_exp[0] = 3'b001;
    g3_exp[1] = 3'b100;
    g3_exp[2] = 3'b001;
    g3_exp[3] = 3'b100;
    for (int k = 0; k < 4; k++) begin
      req3  = 3'b101;
      data3 = 24'hC2_B1_A0;
      #1;
      chk("n3_gnt", int'(gnt3), int'(g3_exp[k]));
      @(posedge clk);
      #1;
      chk("n3_q", int'(q3), (k % 2 == 0) ? 8'hA0 : 8'hC2);
      chk("n3_src", int'(q_src3), (k % 2 == 0) ? 0 : 2);
    end
    req3 = 3'b110;
    #1;
    chk("n3_wrap_gnt", int'(gnt3), 3'b010);
    req3 = 3'b000;
    @(posedge clk);
    #1;

`ifdef SHARED_REG_ARB_LOCK_EN
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lock = 4'b0001;
    repeat (3) cyc(4'b0011, 32'h0000_BBAA, 4'b0001, "lock_gnt");
    lock = 4'b0000;
    cyc(4'b0011, 32'h0000_BBAA, 4'b0010, "unlock_gnt");
    cyc(4'b0000, 32'h0, 4'b0000, "lock_drain_gnt");
`endif

    @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and write sequencer for one shared enable-gated register. Up to N requesters compete for a single W-bit register. Each cycle, at most one requester is selected. The block produces that requester's one-hot grant and the register write enable, and loads the selected data on the next clock edge. It sits in front of shared configuration and data registers, so no requester drives the register enable directly.

## Interface
Parameters:
- N, 4: number of requesters; legal range 2..16.
- W, 8: data width of the shared register.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  N  request per requester; bit i belongs to requester i.
- data  input  N*W  flattened write data; requester i uses bits [i*W +: W].
- lock  input  N  burst-lock request per requester; present only when SHARED_REG_ARB_LOCK_EN is defined.
- gnt  output  N  one-hot grant, combinational; all zeros when no request is pending.
- q  output  W  shared register contents.
- q_valid  output  1  one-cycle pulse: q was written on the last edge.
- q_src  output  $clog2(N)  index of the requester that last wrote q.

## Operation
- The block holds a priority pointer ptr (width $clog2(N)). Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
- Winner is the first index in search order with req set. gnt = one-hot(winner); if no req is set, gnt = 0.
- The internal write enable we equals |req.
- On a rising edge with we=1:
  - q <= data[winner]
  - q_src <= winner
  - q_valid <= 1
  - ptr <= (winner+1) mod N. The wrap is explicit: winner N-1 gives ptr 0, including when N is not a power of two.
- On a rising edge with we=0: q, q_src and ptr hold; q_valid <= 0.
- A requester holding req continuously is granted at most once every N cycles while the other requesters are also requesting. No requester is starved.
- Requester behaviour:
  - A requester drops req after the cycle in which it sees gnt.
  - A requester that keeps req high is treated as issuing a new request.
  - Changes to req within a cycle affect gnt immediately. Only the value at the edge determines the write.
- Reset (rst_n low, at any time, including mid-burst):
  - q = 0, q_valid = 0, q_src = 0, ptr = 0, lock state = IDLE.
  - gnt is forced to 0 while rst_n is low.
  - The first edge after release arbitrates from index 0.

## Timing
- Grant latency: 0 cycles; gnt is valid in the same cycle req is asserted.
- Write latency: 1 cycle; q, q_src and q_valid update on the edge that ends the grant cycle.
- Throughput: one write per cycle when requests are back-to-back.
- Combinational path req -> gnt: N-input rotating priority encoder. The search uses no loops that depend on ptr at runtime.

## Configuration
SHARED_REG_ARB_LOCK_EN (defined):
- Adds the lock input and a two-state FSM, IDLE and LOCKED, with owner register own.
- IDLE -> LOCKED on an edge where the winner w has lock[w]=1 and req[w]=1; own <= w.
- In LOCKED, the winner is forced to own while req[own]&lock[own] is set; other requests are ignored.
- LOCKED -> IDLE on the first edge where req[own] or lock[own] is 0. That cycle arbitrates normally from ptr = (own+1) mod N.
- ptr does not advance during locked cycles.

SHARED_REG_ARB_LOCK_EN (undefined): no lock port and no FSM; pure round-robin as described under Operation.

## Test plan
- Reset check: assert rst_n=0 mid-traffic -> q=0, q_valid=0, q_src=0 and gnt=0 immediately; after release, req=4'b1010 -> gnt=4'b0010.
- Single requester: req=4'b0100, data[2]=8'hA5 for 1 cycle -> gnt=4'b0100 that cycle; next cycle q=8'hA5, q_src=2, q_valid=1; following cycle q_valid=0 and q holds.
- Fairness: req=4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 q_valid pulses.
- Wrap-around with N=3 (non-power-of-two): req=3'b101 held 4 cycles -> grant order 0,2,0,2; ptr never reaches 3.
- Idle hold: after the write of 8'h3C, req=0 for 5 cycles -> q=8'h3C, q_valid=0; the next req=4'b0001 is granted from the saved ptr.
- Lock (macro defined): req=4'b0011, lock=4'b0001 held 3 cycles -> gnt=4'b0001 for all 3; drop lock[0] -> next grant 4'b0010.
